// File: rtl/riscy_pkg.sv
// Shared definitions for the riscy32_single core.
//   fetch_state_t : fetch FSM state encoding (IDLE, REQ, WAIT, HOLD, HALT)
//   INSTR_NOP     : canonical NOP (addi x0, x0, 0) used to blank Instr
//   OP_*          : base RV32I major opcodes decoded by control
//   is_word_aligned() : true when an address has bits [1:0] == 0
package riscy_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
  localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program-counter register with next-PC selection.
//   clk, rst   : clock, asynchronous active-high reset (PC <= RESET_PC)
//   we         : load next_pc into the PC this cycle
//   pc_src     : 1 selects pc_target, 0 selects pc_plus4
//   pc_target  : branch/jump target
//   pc         : current PC
//   pc_plus4   : pc + 4, wrapping modulo 2^XLEN
//   next_pc    : candidate next PC (mux output)
//   misalign   : next_pc is not word aligned
module pc_reg
  import riscy_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  // Plain modular add: 0xFFFF_FFFC + 4 wraps to 0 with no error flagged.
  assign pc_plus4 = pc + XLEN'(4);
  assign next_pc  = pc_src ? pc_target : pc_plus4;
  assign misalign = !is_word_aligned(next_pc[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (we) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter and instruction-fetch stage.
//   clk, rst        : clock, asynchronous active-high reset
//   PCSrc, PCTarget : next-PC select and target, sampled on HOLD & Retire
//   Retire          : core consumed Instr (only meaningful in HOLD)
//   ImemReqValid/ImemReqReady/ImemAddr : fetch request handshake
//   ImemRespValid/ImemRespData         : fetch response
//   Instr, InstrValid : held instruction for decode (NOP when not valid)
//   PC, PCPlus4       : current instruction address and its successor
//   MisalignErr       : sticky, set when a misaligned next PC was selected
module fetch_unit
  import riscy_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            Retire,
  output logic            ImemReqValid,
  input  logic            ImemReqReady,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemRespValid,
  input  logic [31:0]     ImemRespData,
  output logic [31:0]     Instr,
  output logic            InstrValid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            MisalignErr
);

  fetch_state_t    state;
  logic [31:0]     instr_q;
  logic            req_valid;
  logic            instr_valid;
  logic            misalign_err;
  logic            pc_we;
  logic            next_misalign;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;

  // The PC advances only on a clean retire; a misaligned target leaves the
  // PC pointing at the instruction that produced it.
  assign pc_we = (state == HOLD) && Retire && !next_misalign;

  pc_reg #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .we       (pc_we),
    .pc_src   (PCSrc),
    .pc_target(PCTarget),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc),
    .misalign (next_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      instr_q      <= INSTR_NOP;
      req_valid    <= 1'b0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          req_valid <= 1'b1;
          state     <= REQ;
        end
        // Request stays asserted with a stable address until accepted.
        REQ: begin
          if (ImemReqReady) begin
            req_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        // Only place a response is accepted; one request is ever outstanding.
        WAIT: begin
          if (ImemRespValid) begin
            instr_q     <= ImemRespData;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (Retire) begin
            instr_valid <= 1'b0;
            if (next_misalign) begin
              misalign_err <= 1'b1;
              state        <= HALT;
            end else begin
              req_valid <= 1'b1;
              state     <= REQ;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          req_valid   <= 1'b0;
          instr_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign ImemReqValid = req_valid;
  assign ImemAddr     = pc;
  assign InstrValid   = instr_valid;
  // instr_valid is high exactly in HOLD, so this blanks Instr everywhere else.
  assign Instr        = instr_valid ? instr_q : INSTR_NOP;
  assign PC           = pc;
  assign PCPlus4      = pc_plus4;
  assign MisalignErr  = misalign_err;

  // Unused next_pc tap kept visible for debug; fold into a reduction so it
  // is referenced.
  logic next_pc_unused;
  assign next_pc_unused = ^next_pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        Retire;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [31:0] ImemAddr;
  logic        ImemRespValid;
  logic [31:0] ImemRespData;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        MisalignErr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;     // expected fetch address
    logic [31:0] data;     // instruction returned
    int          rdy;      // cycles ImemReqReady held low
    int          rsp;      // extra cycles in WAIT before response
    bit          early;    // drive a response in the acceptance cycle
    bit          spurious; // drive a response while holding
    bit          src;      // PCSrc at retire
    logic [31:0] target;   // PCTarget at retire
    bit          err;      // retire expected to flag misalignment
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[6];

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .Retire       (Retire),
    .ImemReqValid (ImemReqValid),
    .ImemReqReady (ImemReqReady),
    .ImemAddr     (ImemAddr),
    .ImemRespValid(ImemRespValid),
    .ImemRespData (ImemRespData),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .MisalignErr  (MisalignErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input vec_t v);
    int   n;
    exp_t e;
    n = 0;
    while (!ImemReqValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", ImemReqValid, 1);
    if (!ImemReqValid) return;
    chk("req_addr", ImemAddr, v.addr);
    chk("req_pc", PC, v.addr);
    chk("req_pcplus4", PCPlus4, v.addr + 32'd4);
    chk("req_instr_nop", Instr, NOP);
    chk("req_instr_valid", InstrValid, 0);
    for (int i = 0; i < v.rdy; i++) begin
      ImemReqReady = 1'b0;
      @(negedge clk);
      chk("stall_valid", ImemReqValid, 1);
      chk("stall_addr", ImemAddr, v.addr);
    end
    ImemReqReady = 1'b1;
    if (v.early) begin
      ImemRespValid = 1'b1;
      ImemRespData  = 32'hBAD0_BAD0;
    end
    @(negedge clk);
    ImemReqReady  = 1'b0;
    ImemRespValid = 1'b0;
    chk("wait_req_low", ImemReqValid, 0);
    chk("wait_not_valid", InstrValid, 0);
    for (int i = 0; i < v.rsp; i++) begin
      @(negedge clk);
      chk("wait_still", InstrValid, 0);
    end
    ImemRespValid = 1'b1;
    ImemRespData  = v.data;
    sbq.push_back('{v.data, v.addr});
    @(negedge clk);
    ImemRespValid = 1'b0;
    ImemRespData  = $urandom;
    chk("hold_valid", InstrValid, 1);
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk("hold_instr", Instr, e.instr);
    chk("hold_pc", PC, e.pc);
    if (v.spurious) begin
      ImemRespValid = 1'b1;
      ImemRespData  = 32'hDEAD_BEEF;
      @(negedge clk);
      ImemRespValid = 1'b0;
      chk("spur_instr", Instr, e.instr);
      chk("spur_valid", InstrValid, 1);
      chk("spur_noreq", ImemReqValid, 0);
    end
  endtask

  task automatic do_retire(input vec_t v);
    PCSrc    = v.src;
    PCTarget = v.target;
    Retire   = 1'b1;
    @(negedge clk);
    Retire   = 1'b0;
    PCSrc    = 1'($urandom);
    PCTarget = $urandom;
    chk("ret_err", MisalignErr, v.err);
    chk("ret_instr_valid", InstrValid, 0);
    chk("ret_next_req", ImemReqValid, !v.err);
  endtask

  initial begin
    rst           = 1'b1;
    PCSrc         = 1'b0;
    PCTarget      = 32'h0;
    Retire        = 1'b0;
    ImemReqReady  = 1'b0;
    ImemRespValid = 1'b0;
    ImemRespData  = 32'h0;

    tbl[0] = '{32'h0000_0000, 32'h0050_0093, 0, 0, 1'b1, 1'b0, 1'b0, 32'h5555_5550, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h0010_0113, 3, 2, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0};
    tbl[2] = '{32'h0000_0100, 32'h0020_8193, 1, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0};
    tbl[3] = '{32'hFFFF_FFFC, 32'h0031_0213, 0, 1, 1'b0, 1'b1, 1'b0, 32'h0000_0103, 1'b0};
    tbl[4] = '{32'h0000_0000, 32'h0041_8293, 2, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b1};
    tbl[5] = '{32'h0000_0000, 32'h0000_0513, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pc", PC, 32'h0);
    chk("rst_req", ImemReqValid, 0);
    chk("rst_instr", Instr, NOP);
    chk("rst_valid", InstrValid, 0);
    chk("rst_err", MisalignErr, 0);
    rst = 1'b0;
    chk("idle_noreq", ImemReqValid, 0);
    @(negedge clk);
    chk("idle_to_req", ImemReqValid, 1);

    for (int k = 0; k < 5; k++) begin
      do_fetch(tbl[k]);
      do_retire(tbl[k]);
    end

    // Halted: no requests, PC frozen, retire ignored, error sticky
    Retire   = 1'b1;
    PCSrc    = 1'b1;
    PCTarget = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halt_req", ImemReqValid, 0);
      chk("halt_valid", InstrValid, 0);
      chk("halt_instr", Instr, NOP);
      chk("halt_pc", PC, 32'h0);
      chk("halt_err", MisalignErr, 1);
    end
    Retire = 1'b0;

    // Only reset clears the error
    rst = 1'b1;
    #1;
    chk("rst2_err", MisalignErr, 0);
    chk("rst2_pc", PC, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fetch, jump to 0x40, then reset while waiting on the response
    do_fetch(tbl[5]);
    do_retire(tbl[5]);
    chk("pre_wait_pc", PC, 32'h40);
    ImemReqReady = 1'b1;
    @(negedge clk);
    ImemReqReady = 1'b0;
    chk("wait2_req_low", ImemReqValid, 0);
    rst = 1'b1;
    #1;
    chk("midrst_pc", PC, 32'h0);
    chk("midrst_valid", InstrValid, 0);
    chk("midrst_req", ImemReqValid, 0);
    @(negedge clk);
    rst           = 1'b0;
    ImemRespValid = 1'b1;
    ImemRespData  = 32'hCAFE_F00D;
    @(negedge clk);
    ImemRespValid = 1'b0;
    chk("late_resp_valid", InstrValid, 0);
    chk("late_resp_instr", Instr, NOP);
    chk("late_req", ImemReqValid, 1);
    chk("late_addr", ImemAddr, 32'h0);
    repeat (2) @(negedge clk);
    chk("late_still_req", ImemReqValid, 1);
    chk("late_still_invalid", InstrValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage for riscy32_single, directly upstream of control.
- Owns the PC register and issues word fetches to instruction memory over a valid/ready request and valid response interface.
- Holds the returned instruction; its op/funct3/funct7 fields feed control.
- Consumes control's PCSrc and the datapath's PCTarget to select the next PC when the core retires the current instruction.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCSrc  in  1  from control: 1 = take PCTarget, 0 = PC+4.
- PCTarget  in  XLEN  branch/jump target from the datapath adder.
- Retire  in  1  core has consumed Instr this cycle; sampled only in HOLD.
- ImemReqValid  out  1  fetch request valid.
- ImemReqReady  in  1  memory accepts the request.
- ImemAddr  out  XLEN  fetch address; always equals PC.
- ImemRespValid  in  1  response data valid.
- ImemRespData  in  32  fetched instruction word.
- Instr  out  32  held instruction; equals NOP (32'h0000_0013) when InstrValid=0.
- InstrValid  out  1  Instr is valid for decode.
- PC  out  XLEN  address of the current instruction.
- PCPlus4  out  XLEN  PC+4, combinational, wraps modulo 2^XLEN.
- MisalignErr  out  1  sticky: a non-word-aligned next PC was selected.

Behaviour:
- Reset values (asynchronous):
  - PC=RESET_PC, state=IDLE.
  - Instr register=NOP, InstrValid=0, ImemReqValid=0, MisalignErr=0.
- FSM states: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE: single cycle after reset release; always goes to REQ. No request is issued.
- REQ:
  - ImemReqValid=1, ImemAddr=PC.
  - ImemReqValid and ImemAddr must stay stable until ImemReqReady=1.
  - On the edge where ImemReqValid&ImemReqReady, go to WAIT.
- WAIT:
  - ImemReqValid=0.
  - On ImemRespValid, register ImemRespData into Instr and go to HOLD.
  - Waits indefinitely; there is no timeout.
- HOLD:
  - InstrValid=1; Instr and PC are stable.
  - On Retire=1:
    - next PC = PCSrc ? PCTarget : PCPlus4.
    - If the next PC has bits [1:0] != 0: PC is not updated, MisalignErr is set, go to HALT.
    - Otherwise PC <= next PC, go to REQ.
  - On Retire=0, stay in HOLD.
- HALT:
  - Terminal until reset.
  - Outputs are ImemReqValid=0, InstrValid=0, Instr=NOP.
- Instr register contents:
  - The Instr register is reloaded only in WAIT on ImemRespValid.
  - Outside HOLD, the Instr output is forced to NOP.
- Response handling:
  - One outstanding request maximum.
  - ImemRespValid is ignored in every state except WAIT.
  - A response in the same cycle the request is accepted is ignored; the earliest valid response is the cycle after acceptance.
- Timing:
  - Minimum fetch latency with ReqReady=1 and a response one cycle later: REQ at cycle n, WAIT at n+1, HOLD/InstrValid at n+2.
  - The earliest next REQ is the cycle after Retire.
- Arithmetic: PC+4 wraps, so 32'hFFFF_FFFC advances to 32'h0000_0000 with no error.
- Mid-operation reset: rst in any state immediately restores the reset values. Any in-flight response is dropped because the FSM is not in WAIT.
- PCTarget is sampled only on the HOLD&Retire edge. Values at any other time have no effect.

Decomposition:
- riscy_pkg holds:
  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD, HALT).
  - INSTR_NOP = 32'h0000_0013.
  - Opcode constants shared with control.
- Sub-module pc_reg holds the PC flop, RESET_PC load, next-PC mux, PC+4 adder and misalignment check. It has a write-enable driven by the FSM.
- The FSM and the instruction holding register stay in fetch_unit.

Test Plan:
- Reset then ReqReady=1, response 1 cycle after acceptance with data 32'h0050_0093 -> ImemAddr=0 in REQ, InstrValid=1 two cycles later, Instr=32'h0050_0093, PC=0.
- Retire with PCSrc=0 from PC=0 -> next REQ ImemAddr=32'h4. Retire with PCSrc=1, PCTarget=32'h100 -> next ImemAddr=32'h100.
- ReqReady held low 3 cycles -> ImemReqValid stays 1 and ImemAddr stays constant for all 3 cycles; WAIT is entered only after ready.
- Spurious ImemRespValid in HOLD with data 32'hDEAD_BEEF -> Instr unchanged, InstrValid stays 1.
- Retire with PCSrc=1, PCTarget=32'h102 -> MisalignErr=1, state HALT, no further requests, PC unchanged. Only rst clears the error.
- PC=32'hFFFF_FFFC, Retire with PCSrc=0 -> ImemAddr=0, MisalignErr=0. Separately, asserting rst during WAIT -> PC=RESET_PC, InstrValid=0, and a later response is ignored.
